// File: rtl/python_spi_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : python_spi_init_seq
// Description : Replays a ROM register-init table into a PYTHON300 over SPI,
//               then forwards host register writes.
// Revision    : 1.0
// ============================================================================
module python_spi_init_seq #(
    parameter int SCLK_DIV      = 4,
    parameter int SETTLE_CYCLES = 720,
    parameter int DELAY_UNIT    = 720,
    parameter int TBL_AW        = 6
) (
    input  logic              clk72,
    input  logic              reset_n,
    input  logic              pwr_ready,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [8:0]        host_addr,
    input  logic [15:0]       host_data,
    output logic              busy,
    output logic              init_done,
    output logic              spi_ss_n,
    output logic              spi_sck,
    output logic              spi_mosi
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_DELAY  = 3'd6;
    localparam logic [2:0] S_READY  = 3'd7;

    localparam logic [31:0] c_settle_m1 = 32'(SETTLE_CYCLES - 1);
    localparam logic [8:0]  c_div_m1    = 9'(SCLK_DIV - 1);
    localparam logic [8:0]  c_gap_m1    = 9'(2 * SCLK_DIV - 1);
    localparam logic [5:0]  c_last_ph   = 6'd52;

    logic [2:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [8:0]        div_q, div_d;
    logic [5:0]        ph_q, ph_d;
    logic [25:0]       frame_q, frame_d;
    logic              host_op_q, host_op_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
    logic              host_ready_q, host_ready_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic              ss_n_q, ss_n_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;

    logic        w_last, w_end, w_dly, w_div_done, w_hs;
    logic [31:0] w_dly_cnt;
    logic [25:0] w_ld_frame;
    logic [2:0]  w_adv_state;
    logic        w_unused;

    assign w_last      = (tbl_addr_q == {TBL_AW{1'b1}});
    assign w_end       = tbl_data[31];
    assign w_dly       = tbl_data[30];
    assign w_dly_cnt   = 32'(tbl_data[15:0]) * 32'(DELAY_UNIT);
    assign w_div_done  = (div_q == 9'd0);
    assign w_hs        = host_valid & host_ready_q;
    // The final table slot never wraps back to 0: it always finishes in READY.
    assign w_adv_state = w_last ? S_READY : S_FETCH;
    assign w_ld_frame  = (state_q == S_READY) ? {host_addr, 1'b1, host_data}
                                              : {tbl_data[24:16], 1'b1, tbl_data[15:0]};
    assign w_unused    = ^tbl_data[29:25];

    always_ff @(posedge clk72 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            ph_q         <= '0;
            frame_q      <= '0;
            host_op_q    <= 1'b0;
            tbl_addr_q   <= '0;
            host_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            ss_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            ph_q         <= ph_d;
            frame_q      <= frame_d;
            host_op_q    <= host_op_d;
            tbl_addr_q   <= tbl_addr_d;
            host_ready_q <= host_ready_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            ss_n_q       <= ss_n_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && !pwr_ready) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (pwr_ready) state_d = S_SETTLE;
                S_SETTLE: if (cnt_q == 32'd0) state_d = S_FETCH;
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    if (w_end)                  state_d = S_READY;
                    else if (w_dly)             state_d = (w_dly_cnt == 32'd0) ? w_adv_state : S_DELAY;
                    else                        state_d = S_SHIFT;
                end
                S_SHIFT:  if (w_div_done && ph_q == c_last_ph) state_d = S_GAP;
                S_GAP:    if (w_div_done) state_d = host_op_q ? S_READY : w_adv_state;
                S_DELAY:  if (cnt_q == 32'd0) state_d = w_adv_state;
                S_READY:  if (w_hs) state_d = S_SHIFT;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Every output flop is loaded from the next state so outputs stay registered.
    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        ph_d         = ph_q;
        frame_d      = frame_q;
        host_op_d    = host_op_q;
        tbl_addr_d   = tbl_addr_q;
        init_done_d  = init_done_q;
        ss_n_d       = ss_n_q;
        sck_d        = sck_q;
        mosi_d       = mosi_q;
        busy_d       = (state_d != S_IDLE) && (state_d != S_READY);
        host_ready_d = (state_d == S_READY);

        case (state_q)
            S_IDLE:   cnt_d = c_settle_m1;
            S_SETTLE: if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
            S_DECODE: begin
                if (state_d == S_DELAY)      cnt_d = w_dly_cnt - 32'd1;
                else if (state_d == S_FETCH) tbl_addr_d = tbl_addr_q + TBL_AW'(1);
            end
            S_SHIFT: begin
                if (!w_div_done) begin
                    div_d = div_q - 9'd1;
                end else if (ph_q == c_last_ph) begin
                    ss_n_d = 1'b1;
                    sck_d  = 1'b0;
                    mosi_d = 1'b0;
                    div_d  = c_gap_m1;
                end else begin
                    // Odd phases are SCK-high; leaving one starts the next bit.
                    ph_d  = ph_q + 6'd1;
                    div_d = c_div_m1;
                    sck_d = ~ph_q[0];
                    if (ph_q[0]) begin
                        frame_d = {frame_q[24:0], 1'b0};
                        mosi_d  = frame_q[24];
                    end
                end
            end
            S_GAP: begin
                if (!w_div_done)             div_d = div_q - 9'd1;
                else if (state_d == S_FETCH) tbl_addr_d = tbl_addr_q + TBL_AW'(1);
            end
            S_DELAY: begin
                if (cnt_q != 32'd0)          cnt_d = cnt_q - 32'd1;
                else if (state_d == S_FETCH) tbl_addr_d = tbl_addr_q + TBL_AW'(1);
            end
            default: ;
        endcase

        if (state_d == S_SHIFT && state_q != S_SHIFT) begin
            frame_d   = w_ld_frame;
            mosi_d    = w_ld_frame[25];
            ss_n_d    = 1'b0;
            sck_d     = 1'b0;
            div_d     = c_div_m1;
            ph_d      = 6'd0;
            host_op_d = (state_q == S_READY);
        end
        if (state_d == S_READY) init_done_d = 1'b1;
        if (state_d == S_IDLE) begin
            tbl_addr_d  = '0;
            init_done_d = 1'b0;
            ss_n_d      = 1'b1;
            sck_d       = 1'b0;
            mosi_d      = 1'b0;
            host_op_d   = 1'b0;
        end
    end

    assign tbl_addr   = tbl_addr_q;
    assign host_ready = host_ready_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;
    assign spi_ss_n   = ss_n_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_python_spi_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_python_spi_init_seq
// Description : Scoreboard bench for python_spi_init_seq (SCLK_DIV 4 and 2).
// Revision    : 1.0
// ============================================================================
module tb_python_spi_init_seq;

    typedef struct { logic [25:0] frame; int fall; } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   frames_a = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] rom_a [64];
    logic [31:0] rom_b [64];

    logic        pwr_a = 0, hv_a = 0, hr_a, busy_a, done_a, ss_a, sck_a, mosi_a;
    logic [5:0]  addr_a;
    logic [31:0] data_a;
    logic [8:0]  haddr_a = 0;
    logic [15:0] hdata_a = 0;
    logic        pwr_b = 0, hv_b = 0, hr_b, busy_b, done_b, ss_b, sck_b, mosi_b;
    logic [5:0]  addr_b;
    logic [31:0] data_b;
    logic [8:0]  haddr_b = 0;
    logic [15:0] hdata_b = 0;

    python_spi_init_seq #(.SCLK_DIV(4), .SETTLE_CYCLES(720), .DELAY_UNIT(720), .TBL_AW(6)) u_dut_a (
        .clk72(clk), .reset_n(reset_n), .pwr_ready(pwr_a), .tbl_addr(addr_a), .tbl_data(data_a),
        .host_valid(hv_a), .host_ready(hr_a), .host_addr(haddr_a), .host_data(hdata_a),
        .busy(busy_a), .init_done(done_a), .spi_ss_n(ss_a), .spi_sck(sck_a), .spi_mosi(mosi_a));

    python_spi_init_seq #(.SCLK_DIV(2), .SETTLE_CYCLES(37), .DELAY_UNIT(5), .TBL_AW(6)) u_dut_b (
        .clk72(clk), .reset_n(reset_n), .pwr_ready(pwr_b), .tbl_addr(addr_b), .tbl_data(data_b),
        .host_valid(hv_b), .host_ready(hr_b), .host_addr(haddr_b), .host_data(hdata_b),
        .busy(busy_b), .init_done(done_b), .spi_ss_n(ss_b), .spi_sck(sck_b), .spi_mosi(mosi_b));

    always #7 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) data_a <= rom_a[addr_a];
    always @(posedge clk) data_b <= rom_b[addr_b];

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timeline reference: walks the table with the documented per-entry costs.
    task automatic run_model(input int inst, input int drive_cyc, output int ready_edge);
        int div, settle, unit, t;
        logic [31:0] e;
        exp_t x;
        div    = inst ? 2 : 4;
        settle = inst ? 37 : 720;
        unit   = inst ? 5 : 720;
        t      = drive_cyc + 1 + settle;
        for (int i = 0; i < 64; i++) begin
            e = inst ? rom_b[i] : rom_a[i];
            t += 2;
            if (e[31]) break;
            if (e[30]) begin
                t += int'(e[15:0]) * unit;
            end else begin
                x.frame = {e[24:16], 1'b1, e[15:0]};
                x.fall  = t;
                if (inst == 0) qa.push_back(x); else qb.push_back(x);
                t += 55 * div;
            end
        end
        ready_edge = t;
    endtask

    task automatic rise(input int inst, output int ready_edge);
        if (inst == 0) pwr_a = 1'b1; else pwr_b = 1'b1;
        run_model(inst, cyc, ready_edge);
    endtask

    task automatic drop(input int inst);
        if (inst == 0) pwr_a = 1'b0; else pwr_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_ready(input int inst, input int ready_edge);
        if (ready_edge - 1 < cyc) chk("ready_edge_reachable", cyc, ready_edge - 1);
        while (cyc < ready_edge - 1) tick();
        chk("init_done_before_end", inst ? done_b : done_a, 0);
        chk("busy_before_end", inst ? busy_b : busy_a, 1);
        tick();
        chk("init_done_at_end", inst ? done_b : done_a, 1);
        chk("busy_idle_ready", inst ? busy_b : busy_a, 0);
        chk("host_ready_in_ready", inst ? hr_b : hr_a, 1);
        chk("scoreboard_drained", inst ? qb.size() : qa.size(), 0);
    endtask

    task automatic host_req(input logic [8:0] a, input logic [15:0] d, output int hs);
        exp_t x;
        haddr_a = a;
        hdata_a = d;
        hv_a    = 1'b1;
        hs      = -1;
        for (int n = 0; n < 5000; n++) begin
            if (hr_a) begin
                hs      = cyc + 1;
                x.frame = {a, 1'b1, d};
                x.fall  = hs;
                qa.push_back(x);
                break;
            end
            tick();
        end
        if (hs < 0) chk("host_handshake_timeout", 0, 1);
        tick();
        hv_a = 1'b0;
        chk("host_ready_after_accept", hr_a, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || busy_a) && n < 20000) begin
            tick();
            n++;
        end
        chk("drain_queue", qa.size(), 0);
    endtask

    // Monitor state, one slot per DUT.
    logic        m_prev_ss[2], m_prev_sck[2], m_prev_mosi[2], m_active[2], m_bad[2];
    int          m_low[2], m_bits[2], m_fall[2], m_hi[2];
    logic [25:0] m_word[2];

    task automatic mon_step(input int i);
        logic ss, sck, mosi, pwr;
        int div;
        exp_t e;
        ss   = i ? ss_b : ss_a;
        sck  = i ? sck_b : sck_a;
        mosi = i ? mosi_b : mosi_a;
        pwr  = i ? pwr_b : pwr_a;
        div  = i ? 2 : 4;
        if (!ss) begin
            if (m_prev_ss[i]) begin
                m_active[i] = 1'b1; m_fall[i] = cyc; m_low[i] = 0; m_bits[i] = 0;
                m_hi[i] = 0; m_word[i] = '0; m_bad[i] = 1'b0;
            end else if (mosi != m_prev_mosi[i] && !(!sck && m_prev_sck[i])) begin
                m_bad[i] = 1'b1;
            end
            m_low[i]++;
            if (sck) m_hi[i]++;
            if (sck && !m_prev_sck[i]) begin
                m_word[i] = {m_word[i][24:0], mosi};
                m_bits[i]++;
            end
            if (!sck && m_prev_sck[i]) begin
                if (m_hi[i] != div) m_bad[i] = 1'b1;
                m_hi[i] = 0;
            end
        end else if (!m_prev_ss[i] && m_active[i]) begin
            m_active[i] = 1'b0;
            if (pwr) begin
                if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame inst=%0d actual=%h required=none", i, m_word[i]);
                end else begin
                    if (i == 0) e = qa.pop_front(); else e = qb.pop_front();
                    chk("frame_payload", m_word[i], e.frame);
                    chk("frame_ss_fall_cycle", m_fall[i], e.fall);
                    chk("ss_low_cycles", m_low[i], 53 * div);
                    chk("frame_bit_count", m_bits[i], 26);
                    chk("sck_mosi_timing", m_bad[i], 0);
                    if (i == 0) frames_a++;
                end
            end
        end
        m_prev_ss[i]   = ss;
        m_prev_sck[i]  = sck;
        m_prev_mosi[i] = mosi;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_prev_ss[i] = 1'b1; m_prev_sck[i] = 1'b0; m_prev_mosi[i] = 1'b0;
            m_active[i] = 1'b0; m_bad[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (reset_n) for (int i = 0; i < 2; i++) mon_step(i);
        end
    end

    initial begin
        int r, h1, h2, n, f0, fstart, pos_end;
        for (int i = 0; i < 64; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tbl_addr", addr_a, 0);
        chk("rst_host_ready", hr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_init_done", done_a, 0);
        chk("rst_ss_n", ss_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi_a, 0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_without_power", busy_a, 0);

        // Basic replay: one write then end marker
        rom_a[0] = {2'b00, 5'd0, 9'h007, 16'h0001};
        rom_a[1] = 32'h8000_0000;
        rise(0, r);
        wait_ready(0, r);

        // Host writes: single, busy window, held request, random
        host_req(9'h0C0, 16'h1234, h1);
        n = 0;
        while (busy_a && n < 2000) begin n++; tick(); end
        chk("host_busy_cycles", n, 53 * 4 + 8);
        host_req(9'($urandom), 16'($urandom), h1);
        host_req(9'($urandom), 16'($urandom), h2);
        chk("held_request_after_gap", h2 - h1, 55 * 4 + 1);
        repeat (3) begin
            repeat ($urandom_range(0, 20)) tick();
            host_req(9'($urandom), 16'($urandom), h1);
        end
        drain();
        drop(0);

        // Delay entry, then abort during frame 0 and full replay
        rom_a[0] = {2'b01, 5'd0, 9'h000, 16'd3};
        rom_a[1] = {2'b00, 5'd0, 9'h020, 16'hABCD};
        rom_a[2] = 32'h8000_0000;
        f0 = cyc;
        rise(0, r);
        fstart = -1;
        for (int k = 0; k < 5000; k++) begin
            if (!ss_a) begin fstart = cyc; break; end
            tick();
        end
        chk("delay_shifts_first_frame", fstart, f0 + 1 + 720 + 2 + 2 + 3 * 720);
        repeat (90) tick();
        pwr_a = 1'b0;
        qa.delete();
        tick();
        chk("abort_ss_n", ss_a, 1);
        chk("abort_sck", sck_a, 0);
        chk("abort_mosi", mosi_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_init_done", done_a, 0);
        chk("abort_host_ready", hr_a, 0);
        chk("abort_tbl_addr", addr_a, 0);
        tick();
        rise(0, r);
        wait_ready(0, r);
        drop(0);

        // No end marker: 64 random writes, no wrap
        for (int i = 0; i < 64; i++) rom_a[i] = {2'b00, 5'd0, 9'($urandom), 16'($urandom)};
        n = frames_a;
        rise(0, r);
        wait_ready(0, r);
        chk("no_end_frame_count", frames_a - n, 64);
        chk("no_end_tbl_addr", addr_a, 63);
        drop(0);

        // Random mix with an early host request held off until init_done
        pos_end = $urandom_range(4, 12);
        for (int i = 0; i < 64; i++) begin
            if (i == pos_end)                   rom_a[i] = {1'b1, 31'($urandom)};
            else if ($urandom_range(0, 9) < 3)  rom_a[i] = {2'b01, 14'($urandom), 16'($urandom_range(0, 2))};
            else                                rom_a[i] = {2'b00, 5'($urandom), 9'($urandom), 16'($urandom)};
        end
        rise(0, r);
        host_req(9'($urandom), 16'($urandom), h1);
        chk("early_request_held_off", h1, r + 1);
        drain();
        drop(0);

        // SCLK_DIV=2 instance with short settle and delay unit
        for (int i = 0; i < 6; i++) rom_b[i] = {2'b00, 5'd0, 9'($urandom), 16'($urandom)};
        rom_b[6] = {2'b01, 14'd0, 16'($urandom_range(1, 3))};
        rom_b[7] = {2'b00, 5'd0, 9'($urandom), 16'($urandom)};
        rom_b[8] = 32'hC000_0005;
        rise(1, r);
        wait_ready(1, r);
        drop(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/python_spi_init_seq.md
Name: python_spi_init_seq

Overview:
- Downstream of the sensor power manager. Once the sensor power rails and reset sequencing report ready, this block replays a register-initialisation table into the PYTHON300 over SPI.
- Table entries are fetched from an external synchronous ROM. Entries are either register writes or timed delays.
- After the table completes, the block accepts runtime register writes from a host valid/ready port.
- Any loss of power-ready aborts activity and returns the block to idle.

Parameters:
- SCLK_DIV, 4, clk72 cycles per SCK half-period (4 gives 9 MHz); legal range 2..255.
- SETTLE_CYCLES, 720, clk72 cycles to wait after pwr_ready rises before the first fetch (10 us).
- DELAY_UNIT, 720, clk72 cycles per delay-entry count.
- TBL_AW, 6, table address width (64 entries).

Ports:
- clk72  in  1  system clock, 72 MHz
- reset_n  in  1  asynchronous active-low reset
- pwr_ready  in  1  sensor powered and out of reset; level, synchronous to clk72
- tbl_addr  out  TBL_AW  ROM address
- tbl_data  in  32  ROM data, valid 1 cycle after tbl_addr; [31]=end, [30]=delay, [24:16]=reg addr, [15:0]=data or delay count
- host_valid  in  1  runtime write request
- host_ready  out  1  request accepted this cycle
- host_addr  in  9  runtime register address
- host_data  in  16  runtime register data
- busy  out  1  sequence or SPI frame in progress
- init_done  out  1  table completed; held while pwr_ready stays high
- spi_ss_n  out  1  SPI chip select, active low
- spi_sck  out  1  SPI clock, mode 0, idle low
- spi_mosi  out  1  SPI data, MSB first

Behaviour:
- Clock and reset: one clock, clk72. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, tbl_addr=0, host_ready=0, busy=0, init_done=0, spi_ss_n=1, spi_sck=0, spi_mosi=0.
- States: IDLE, SETTLE, FETCH, DECODE, SHIFT, GAP, DELAY, READY.
- IDLE -> SETTLE when pwr_ready=1.
- SETTLE: counts SETTLE_CYCLES, then goes to FETCH with tbl_addr=0.
- FETCH: drives tbl_addr, waits 1 cycle for ROM latency, then DECODE.
- DECODE:
  - end=1 -> READY.
  - delay=1 -> DELAY with count = data[15:0]*DELAY_UNIT. A count of 0 advances immediately.
  - Otherwise load the 26-bit frame {addr[8:0], 1'b1, data[15:0]} -> SHIFT.
  - end takes priority over delay.
- SHIFT:
  - spi_ss_n=0 for the whole frame.
  - Each bit is a low phase of SCLK_DIV cycles followed by a high phase of SCLK_DIV cycles. spi_mosi changes only at the start of a low phase.
  - After the 26th high phase: one tail low phase of SCLK_DIV cycles, then spi_ss_n=1.
  - spi_ss_n low time is exactly 53*SCLK_DIV cycles.
- GAP: spi_ss_n high for 2*SCLK_DIV cycles. Then:
  - During table replay: increment tbl_addr -> FETCH.
  - For a host write: -> READY.
- DELAY: count down, then increment tbl_addr -> FETCH.
- Table wrap-around: if tbl_addr reaches 2^TBL_AW-1 without an end entry, that entry is processed, and the sequence then goes to READY (no wrap).
- READY:
  - init_done=1, busy=0 while idle here.
  - host_ready=1 only in READY with no frame active. A handshake (valid & ready) captures host_addr/host_data, and the frame starts SHIFT the next cycle.
  - busy=1 from capture through the end of GAP.
- Host port: host_ready=0 in every state other than READY. Requests before init_done are held off, never dropped.
- Abort: pwr_ready=0 in any state other than IDLE, same cycle -> IDLE on the next edge. Next cycle:
  - spi_ss_n=1, spi_sck=0, spi_mosi=0
  - busy=0, init_done=0, host_ready=0, tbl_addr=0
- Partial frames are discarded, not resumed. A later pwr_ready rise replays the full table from entry 0.
- busy=1 in SETTLE, FETCH, DECODE, SHIFT, GAP, DELAY.
- All outputs are registered.

Test Plan:
- Basic replay: reset, pwr_ready=1; ROM[0]={addr 0x007, data 0x0001}, ROM[1]=end.
  - First spi_ss_n fall exactly 720+2 cycles after pwr_ready.
  - MOSI decodes to 26'b000000111_1_0000000000000001.
  - spi_ss_n low 212 cycles; init_done=1 after the GAP.
- Delay entry: ROM[0]=delay count 3, ROM[1]=write 0x020/0xABCD, ROM[2]=end.
  - ss_n fall occurs 2160 cycles later than without the delay; frame payload matches.
- Abort mid-frame: drop pwr_ready after bit 10 of frame 0.
  - Next cycle: ss_n=1, sck=0, busy=0, tbl_addr=0.
  - Reassert pwr_ready: full replay from ROM[0] including SETTLE.
- Host write: after init_done, host_valid with addr 0x0C0/data 0x1234.
  - host_ready high one cycle, one frame emitted, busy high for 53*4+8 cycles.
  - A host_valid held during that frame is accepted only after the GAP.
- No end marker: fill all 64 entries with writes.
  - Exactly 64 frames, then init_done=1; tbl_addr never wraps to 0.
- SCLK_DIV=2: SCK period 4 cycles, ss_n low 106 cycles, payload correct.
